// File: rtl/wb_mem_reader_pkg.sv
// Shared types and constants for the Wishbone block reader and its prefetch FIFO.
// The FSM encoding is exported so debug ports and checkers agree on state values.
package wb_mem_reader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        DRAIN    = 3'd3,
        STOPPING = 3'd4
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;
    localparam int         WORD_BYTES = 4;
    localparam int         FIFO_W     = 33;

    function automatic logic [31:0] word_align(input logic [31:0] i_addr);
        return {i_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_mem_reader_fifo.sv
// Small synchronous FIFO holding {last, data} words between the bus and the stream side.
// Flush has priority over push and pop; push when full and pop when empty are ignored.
module wb_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is cleared on reset so the stream data output reads zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_mem_reader.sv
// Read-only Wishbone classic initiator that fetches a block of words and replays it
// as a valid/ready word stream, with one bus transaction outstanding at most.
module wb_mem_reader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int LEN_W       = 10,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                          io_wbm_clk,
    input  logic                          io_wbm_rst_n,
    input  logic                          cfg_start,
    input  logic                          cfg_stop,
    input  logic [31:0]                   cfg_base_addr,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic                          cfg_loop,
    output logic                          sts_busy,
    output logic                          sts_done,
    output logic                          sts_err,
    output logic [31:0]                   io_wbm_adr,
    output logic [31:0]                   io_wbm_datwr,
    input  logic [31:0]                   io_wbm_datrd,
    output logic                          io_wbm_we,
    output logic [3:0]                    io_wbm_sel,
    output logic                          io_wbm_stb,
    output logic                          io_wbm_cyc,
    input  logic                          io_wbm_ack,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [2:0]                    o_dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   o_dbg_fifo_count
);

    import wb_mem_reader_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [LEN_W-1:0] ONE_WORD = LEN_W'(1);

    state_t             r_state;
    logic [31:0]        r_adr;
    logic [31:0]        r_base;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_remain;
    logic               r_loop;
    logic               r_stb;
    logic               r_done;
    logic               r_err;
    logic [TMO_W-1:0]   r_tmo;

    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_timeout;
    logic               w_last_word;
    logic               w_empty;
    logic               w_full;
    logic [CNT_W-1:0]   w_count;
    logic [FIFO_W-1:0]  w_head;

    // Stream handshake: a word moves on any cycle where tvalid and tready are both
    // high; tdata/tlast come straight from the FIFO head and so hold while stalled.
    assign w_last_word = (r_remain == ONE_WORD);
    assign w_timeout   = (ACK_TIMEOUT != 0) && r_stb && !io_wbm_ack && (r_tmo == TMO_LAST);
    assign w_push      = (r_state == WAIT_ACK) && r_stb && io_wbm_ack && !cfg_stop;
    assign w_flush     = w_timeout || ((r_state == STOPPING) && (!r_stb || io_wbm_ack));
    assign w_pop       = !w_empty && m_axis_tready;

    wb_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .i_clk   (io_wbm_clk),
        .i_rst_n (io_wbm_rst_n),
        .i_push  (w_push),
        .i_data  ({w_last_word, io_wbm_datrd}),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge io_wbm_clk or negedge io_wbm_rst_n) begin
        if (!io_wbm_rst_n) begin
            r_state  <= IDLE;
            r_adr    <= '0;
            r_base   <= '0;
            r_len    <= '0;
            r_remain <= '0;
            r_loop   <= 1'b0;
            r_stb    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_err    <= 1'b0;
                        r_base   <= word_align(cfg_base_addr);
                        r_adr    <= word_align(cfg_base_addr);
                        r_len    <= cfg_len;
                        r_remain <= cfg_len;
                        r_loop   <= cfg_loop;
                        if (cfg_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The previous word is already in the FIFO here, so nothing is in flight.
                    if (cfg_stop) begin
                        r_state <= STOPPING;
                    end else if (!w_full) begin
                        r_stb   <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (w_timeout) begin
                        r_stb   <= 1'b0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (cfg_stop) begin
                        if (io_wbm_ack) begin
                            r_stb <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
                        r_state <= STOPPING;
                    end else if (io_wbm_ack) begin
                        r_stb <= 1'b0;
                        if (!w_last_word) begin
                            r_adr    <= r_adr + 32'(WORD_BYTES);
                            r_remain <= r_remain - ONE_WORD;
                            r_state  <= ISSUE;
                        end else if (r_loop) begin
                            r_adr    <= r_base;
                            r_remain <= r_len;
                            r_state  <= ISSUE;
                        end else begin
                            r_remain <= '0;
                            r_state  <= DRAIN;
                        end
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                DRAIN: begin
                    if (cfg_stop) begin
                        r_state <= STOPPING;
                    end else if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                STOPPING: begin
                    // A late ack is absorbed here and its data never reaches the FIFO.
                    if (w_timeout) begin
                        r_stb   <= 1'b0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (!r_stb || io_wbm_ack) begin
                        r_stb   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                    r_stb   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sts_busy         = (r_state != IDLE);
    assign sts_done         = r_done;
    assign sts_err          = r_err;
    assign io_wbm_adr       = r_adr;
    assign io_wbm_datwr     = 32'h0;
    assign io_wbm_we        = 1'b0;
    assign io_wbm_stb       = r_stb;
    assign io_wbm_cyc       = r_stb;
    assign io_wbm_sel       = r_stb ? WB_SEL_ALL : 4'h0;
    assign m_axis_tvalid    = !w_empty;
    assign m_axis_tdata     = w_head[31:0];
    assign m_axis_tlast     = w_head[32];
    assign o_dbg_state      = r_state;
    assign o_dbg_fifo_count = w_count;

endmodule

// File: tb/tb_wb_mem_reader.sv
// Bench for wb_mem_reader: table of transfers, hand sequences for stop/timeout/reset,
// and randomized transfers checked against a word-list model of the memory block.
module tb_wb_mem_reader;

    localparam int FIFO_DEPTH  = 4;
    localparam int LEN_W       = 10;
    localparam int ACK_TIMEOUT = 16;

    logic              io_wbm_clk    = 1'b0;
    logic              io_wbm_rst_n  = 1'b0;
    logic              cfg_start     = 1'b0;
    logic              cfg_stop      = 1'b0;
    logic [31:0]       cfg_base_addr = 32'h0;
    logic [LEN_W-1:0]  cfg_len       = '0;
    logic              cfg_loop      = 1'b0;
    logic              sts_busy, sts_done, sts_err;
    logic [31:0]       io_wbm_adr, io_wbm_datwr;
    logic [31:0]       io_wbm_datrd  = 32'hDEAD_BEEF;
    logic              io_wbm_we, io_wbm_stb, io_wbm_cyc;
    logic [3:0]        io_wbm_sel;
    logic              io_wbm_ack    = 1'b0;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast;
    logic              m_axis_tready = 1'b0;
    logic [2:0]        dbg_state;
    logic [2:0]        dbg_fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    logic [31:0] exp_adr_q[$];
    logic [31:0] obs_adr_q[$];

    int stb_edges = 0;
    int done_cnt  = 0;
    bit no_ack     = 1'b0;
    bit rand_ack   = 1'b0;
    bit rand_ready = 1'b0;
    int ack_delay  = 1;
    int cur_delay  = 1;
    int rsp_cnt    = 0;

    bit          prev_stb   = 1'b0;
    bit          prev_done  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_adr   = 32'h0;
    logic [32:0] prev_head  = '0;

    wb_mem_reader #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .LEN_W       (LEN_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .io_wbm_clk       (io_wbm_clk),
        .io_wbm_rst_n     (io_wbm_rst_n),
        .cfg_start        (cfg_start),
        .cfg_stop         (cfg_stop),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_len          (cfg_len),
        .cfg_loop         (cfg_loop),
        .sts_busy         (sts_busy),
        .sts_done         (sts_done),
        .sts_err          (sts_err),
        .io_wbm_adr       (io_wbm_adr),
        .io_wbm_datwr     (io_wbm_datwr),
        .io_wbm_datrd     (io_wbm_datrd),
        .io_wbm_we        (io_wbm_we),
        .io_wbm_sel       (io_wbm_sel),
        .io_wbm_stb       (io_wbm_stb),
        .io_wbm_cyc       (io_wbm_cyc),
        .io_wbm_ack       (io_wbm_ack),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .o_dbg_state      (dbg_state),
        .o_dbg_fifo_count (dbg_fifo_count)
    );

    // ---------------- clock ----------------
    always #5 io_wbm_clk = ~io_wbm_clk;

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a - 32'h100) >> 2) * 32'd3;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Word i of a pass is the memory word at base + 4*i; tlast marks the end of each pass.
    task automatic build_expected(input logic [31:0] base, input int len, input int nwords);
        logic [31:0] a;
        int k;
        exp_q.delete();
        exp_adr_q.delete();
        for (int i = 0; i < nwords; i++) begin
            k = i % len;
            a = {base[31:2], 2'b00} + 32'(4 * k);
            exp_q.push_back({(k == len - 1), mem_word(a)});
            exp_adr_q.push_back(a);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_adr_q.delete();
    endtask

    task automatic compare_stream(input string nm);
        int n;
        check({nm, "_words"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_word%0d", nm, i), 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    task automatic compare_adr(input string nm);
        int n;
        check({nm, "_adr_count"}, 64'(obs_adr_q.size()), 64'(exp_adr_q.size()));
        n = (obs_adr_q.size() < exp_adr_q.size()) ? obs_adr_q.size() : exp_adr_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_adr%0d", nm, i), 64'(obs_adr_q[i]), 64'(exp_adr_q[i]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_xfer(input logic [31:0] base, input int len, input bit loop, input bit with_stop);
        @(posedge io_wbm_clk); #1;
        cfg_base_addr = base;
        cfg_len       = LEN_W'(len);
        cfg_loop      = loop;
        cfg_start     = 1'b1;
        cfg_stop      = with_stop;
        @(posedge io_wbm_clk); #1;
        cfg_start     = 1'b0;
        cfg_stop      = 1'b0;
    endtask

    task automatic stop_pulse();
        @(posedge io_wbm_clk); #1;
        cfg_stop = 1'b1;
        @(posedge io_wbm_clk); #1;
        cfg_stop = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge io_wbm_clk);
            n++;
        end
        repeat (3) @(posedge io_wbm_clk);
        #1;
        check({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({nm, "_busy_low"}, 64'(sts_busy), 64'd0);
    endtask

    // Responder: acks cur_delay cycles after stb rises; datrd is garbage off-ack.
    always @(negedge io_wbm_clk) begin
        if (io_wbm_ack) begin
            io_wbm_ack   = 1'b0;
            io_wbm_datrd = 32'hDEAD_BEEF;
            rsp_cnt      = 0;
        end else if (io_wbm_stb && !no_ack) begin
            if (rsp_cnt == 0) cur_delay = rand_ack ? int'($urandom_range(1, 3)) : ack_delay;
            rsp_cnt++;
            if (rsp_cnt >= cur_delay) begin
                io_wbm_ack   = 1'b1;
                io_wbm_datrd = mem_word(io_wbm_adr);
            end
        end else begin
            rsp_cnt = 0;
        end
    end

    always @(posedge io_wbm_clk) begin
        if (rand_ready) begin
            #1;
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge io_wbm_clk) begin
        if (!io_wbm_rst_n) begin
            prev_stb   = 1'b0;
            prev_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (io_wbm_stb && !prev_stb) begin
                stb_edges++;
                obs_adr_q.push_back(io_wbm_adr);
                check("cyc_sel_on_stb", 64'({io_wbm_cyc, io_wbm_sel}), 64'h1F);
            end
            if (io_wbm_stb && prev_stb)
                check("adr_hold", 64'(io_wbm_adr), 64'(prev_adr));
            if (!io_wbm_stb && prev_stb)
                check("cyc_sel_off", 64'({io_wbm_cyc, io_wbm_sel}), 64'h0);
            if (sts_done) begin
                done_cnt++;
                check("done_single_cycle", 64'(prev_done), 64'd0);
            end
            if (prev_stall)
                check("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, prev_head}));
            if (m_axis_tvalid && m_axis_tready)
                obs_q.push_back({m_axis_tlast, m_axis_tdata});
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_head  = {m_axis_tlast, m_axis_tdata};
            prev_stb   = io_wbm_stb;
            prev_adr   = io_wbm_adr;
            prev_done  = sts_done;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] base;
        int          len;
        int          exp_stb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int e0, d0, n, hi;
        bit seen;
        logic [31:0] rbase;
        int rlen;

        vecs[0] = '{32'h0000_0100, 4, 4};
        vecs[1] = '{32'h0000_0103, 2, 2};
        vecs[2] = '{32'hFFFF_FFF8, 4, 4};
        vecs[3] = '{32'h0000_0200, 1, 1};
        vecs[4] = '{32'h0000_0000, 0, 0};

        // Reset state
        repeat (3) @(posedge io_wbm_clk);
        #1;
        check("rst_bus_ctl", 64'({io_wbm_stb, io_wbm_cyc, io_wbm_sel, io_wbm_we}), 64'h0);
        check("rst_adr", 64'(io_wbm_adr), 64'h0);
        check("rst_datwr", 64'(io_wbm_datwr), 64'h0);
        check("rst_stream", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'h0);
        check("rst_status", 64'({sts_busy, sts_done, sts_err}), 64'h0);
        @(negedge io_wbm_clk);
        io_wbm_rst_n = 1'b1;

        // Table-driven single-pass transfers
        m_axis_tready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clear_obs();
            e0 = stb_edges;
            d0 = done_cnt;
            build_expected(vecs[v].base, vecs[v].len, vecs[v].len);
            start_xfer(vecs[v].base, vecs[v].len, 1'b0, 1'b0);
            wait_done(d0, $sformatf("vec%0d", v));
            compare_stream($sformatf("vec%0d", v));
            compare_adr($sformatf("vec%0d", v));
            check($sformatf("vec%0d_stb_edges", v), 64'(stb_edges - e0), 64'(vecs[v].exp_stb));
        end

        // Backpressure, plus a start while busy that must be ignored
        clear_obs();
        m_axis_tready = 1'b0;
        build_expected(32'h100, 8, 8);
        e0 = stb_edges;
        d0 = done_cnt;
        start_xfer(32'h100, 8, 1'b0, 1'b0);
        repeat (20) @(posedge io_wbm_clk);
        #1;
        check("bp_fetched", 64'(stb_edges - e0), 64'(FIFO_DEPTH));
        check("bp_stb_low", 64'(io_wbm_stb), 64'd0);
        check("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
        start_xfer(32'h500, 1, 1'b0, 1'b0);
        check("bp_start_ignored", 64'(stb_edges - e0), 64'(FIFO_DEPTH));
        m_axis_tready = 1'b1;
        wait_done(d0, "bp");
        compare_stream("bp");
        compare_adr("bp");

        // Start and stop in the same idle cycle: start wins
        clear_obs();
        build_expected(32'h100, 2, 2);
        d0 = done_cnt;
        start_xfer(32'h100, 2, 1'b0, 1'b1);
        wait_done(d0, "start_stop");
        compare_stream("start_stop");

        // Looping playback, stopped after 10 words
        clear_obs();
        build_expected(32'h0, 3, 10);
        d0 = done_cnt;
        start_xfer(32'h0, 3, 1'b1, 1'b0);
        n = 0;
        while (obs_q.size() < 10 && n < 500) begin
            @(posedge io_wbm_clk);
            n++;
        end
        check("loop_enough_words", 64'(obs_q.size() >= 10), 64'd1);
        check("loop_no_done", 64'(done_cnt - d0), 64'd0);
        check("loop_busy", 64'(sts_busy), 64'd1);
        stop_pulse();
        wait_done(d0, "loop_stop");
        while (obs_q.size() > 10) void'(obs_q.pop_back());
        while (obs_adr_q.size() > 6) void'(obs_adr_q.pop_back());
        while (exp_adr_q.size() > 6) void'(exp_adr_q.pop_back());
        compare_stream("loop");
        compare_adr("loop");

        // Stop while waiting for a slow ack
        clear_obs();
        ack_delay = 3;
        d0 = done_cnt;
        start_xfer(32'h100, 4, 1'b0, 1'b0);
        n = 0;
        while (!io_wbm_stb && n < 50) begin
            @(negedge io_wbm_clk);
            n++;
        end
        check("stop_stb_seen", 64'(io_wbm_stb), 64'd1);
        stop_pulse();
        check("stop_stb_held", 64'(io_wbm_stb), 64'd1);
        wait_done(d0, "stop");
        check("stop_discarded", 64'(obs_q.size()), 64'd0);
        check("stop_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("stop_err", 64'(sts_err), 64'd0);
        ack_delay = 1;
        clear_obs();
        build_expected(32'h100, 2, 2);
        d0 = done_cnt;
        start_xfer(32'h100, 2, 1'b0, 1'b0);
        wait_done(d0, "after_stop");
        compare_stream("after_stop");

        // Ack timeout
        clear_obs();
        no_ack = 1'b1;
        d0 = done_cnt;
        start_xfer(32'h100, 2, 1'b0, 1'b0);
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge io_wbm_clk);
            if (io_wbm_stb) begin
                hi++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("tmo_stb_cycles", 64'(hi), 64'(ACK_TIMEOUT));
        wait_done(d0, "tmo");
        check("tmo_err", 64'(sts_err), 64'd1);
        check("tmo_tvalid", 64'(m_axis_tvalid), 64'd0);
        no_ack = 1'b0;
        clear_obs();
        build_expected(32'h100, 1, 1);
        d0 = done_cnt;
        start_xfer(32'h100, 1, 1'b0, 1'b0);
        check("tmo_err_cleared", 64'(sts_err), 64'd0);
        wait_done(d0, "tmo_recover");
        compare_stream("tmo_recover");

        // Randomized transfers with random ready and ack latency
        rand_ready = 1'b1;
        rand_ack   = 1'b1;
        for (int r = 0; r < 8; r++) begin
            clear_obs();
            rbase = $urandom;
            rlen  = int'($urandom_range(1, 12));
            build_expected(rbase, rlen, rlen);
            e0 = stb_edges;
            d0 = done_cnt;
            start_xfer(rbase, rlen, 1'b0, 1'b0);
            wait_done(d0, $sformatf("rnd%0d", r));
            compare_stream($sformatf("rnd%0d", r));
            compare_adr($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_stb_edges", r), 64'(stb_edges - e0), 64'(rlen));
        end
        rand_ready = 1'b0;
        rand_ack   = 1'b0;
        repeat (2) @(posedge io_wbm_clk);
        #2;

        // Asynchronous reset mid-transfer
        m_axis_tready = 1'b0;
        start_xfer(32'h100, 8, 1'b0, 1'b0);
        repeat (12) @(posedge io_wbm_clk);
        #1;
        check("arst_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
        #2;
        io_wbm_rst_n = 1'b0;
        #1;
        check("arst_bus", 64'({io_wbm_stb, io_wbm_cyc}), 64'd0);
        check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("arst_status", 64'({sts_busy, sts_done, sts_err}), 64'd0);
        @(negedge io_wbm_clk);
        #2;
        io_wbm_rst_n = 1'b1;
        repeat (2) @(posedge io_wbm_clk);
        #1;
        check("arst_idle", 64'({sts_busy, io_wbm_stb, m_axis_tvalid}), 64'd0);
        m_axis_tready = 1'b1;
        clear_obs();
        e0 = stb_edges;
        d0 = done_cnt;
        start_xfer(32'h100, 0, 1'b0, 1'b0);
        check("len0_done_next_cycle", 64'(sts_done), 64'd1);
        wait_done(d0, "len0");
        check("len0_no_bus", 64'(stb_edges - e0), 64'd0);
        check("len0_no_data", 64'(obs_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mem_reader.md
Name: wb_mem_reader

Overview:
- Wishbone classic read-only initiator that fetches a block of 32-bit words from the shared SRAM responder and emits them as an AXI-Stream-style word stream, for example to waveform-generator outputs.
- Sits between the user-area Wishbone interconnect (master side) and a stream consumer.
- Keeps one bus transaction outstanding at most and prefetches into a small FIFO.
- Supports single-pass and looping playback.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, at least 2)
LEN_W, 10, width of word-count field (max 1023 words per pass)
ACK_TIMEOUT, 255, cycles to wait for io_wbm_ack before aborting with error (0 disables the timeout)

Ports:
io_wbm_clk  in  1  clock
io_wbm_rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  single-cycle pulse; begin transfer when idle
cfg_stop  in  1  single-cycle pulse; abort transfer
cfg_base_addr  in  32  byte address of first word; bits [1:0] ignored
cfg_len  in  LEN_W  words per pass
cfg_loop  in  1  1 = restart at base after the last word
sts_busy  out  1  transfer active
sts_done  out  1  one-cycle pulse when a transfer ends (normally, by stop, or by error)
sts_err  out  1  sticky ack-timeout flag; cleared by cfg_start
io_wbm_adr  out  32  word-aligned address
io_wbm_datwr  out  32  constant 0
io_wbm_datrd  in  32  read data
io_wbm_we  out  1  constant 0
io_wbm_sel  out  4  4'hF while stb is high, else 0
io_wbm_stb  out  1  strobe
io_wbm_cyc  out  1  cycle; equals stb
io_wbm_ack  in  1  acknowledge
m_axis_tdata  out  32  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  marks the last word of each pass

Behaviour:
- Reset (async, io_wbm_rst_n=0):
  - Outputs: stb=cyc=0, adr=0, sel=0, tvalid=0, tlast=0, tdata=0, busy=0, done=0, err=0.
  - State: FIFO empty, state IDLE.
- FSM states:
  - IDLE: on cfg_start, latch base, len and loop; clear err.
    - len=0: done pulses the next cycle and no bus traffic occurs.
    - Otherwise go to ISSUE. busy=1 in every state except IDLE.
  - ISSUE: entered only when FIFO free slots > 0 (counting the in-flight word).
    - Drive adr = current address, stb=cyc=1, sel=F. Go to WAIT_ACK.
  - WAIT_ACK: hold adr, stb and cyc stable until a cycle with ack=1.
    - On that edge: capture io_wbm_datrd into the FIFO together with a last flag, and drop stb and cyc.
    - If words remain, go to ISSUE; otherwise go to DRAIN.
    - A back-to-back ISSUE may assert stb on the very next cycle; the responder acks 1 cycle after stb, so sustained throughput is 1 word per 2 cycles.
  - DRAIN: wait for the FIFO to empty, then pulse done and go to IDLE.
  - STOPPING: wait for the outstanding ack, if any, and discard its data. Flush the FIFO, pulse done, go to IDLE.
- Address and count:
  - Address increments by 4 per acked word and wraps modulo 2^32.
  - Remaining-word counter decrements on each ack.
  - On the last word with loop=1: address reloads to base, counter reloads to len, and the FSM goes to ISSUE, never DRAIN. tlast is still set on that word.
- Stream side:
  - tvalid = FIFO not empty; tdata and tlast come from the FIFO head.
  - Pop on tvalid & tready.
  - tdata and tlast hold stable while tvalid=1 and tready=0.
  - FIFO never overflows: ISSUE is blocked while occupancy + in-flight = FIFO_DEPTH.
- cfg_stop:
  - In IDLE it is ignored.
  - Otherwise it always goes to STOPPING. A bus cycle is never dropped mid-transaction.
  - cfg_stop and cfg_start in the same cycle while IDLE: start wins.
- cfg_start while busy: ignored.
- Timeout: if ack does not arrive within ACK_TIMEOUT cycles of stb rising, drop stb and cyc, set err, flush the FIFO, pulse done, go to IDLE.
- Simultaneous FIFO push (ack) and pop in the same cycle are both honoured.
- io_wbm_datrd is sampled only on ack cycles.

Decomposition:
- Shared package wb_mem_reader_pkg:
  - state enum {IDLE, ISSUE, WAIT_ACK, DRAIN, STOPPING}
  - WB_SEL_ALL = 4'hF
  - WORD_BYTES = 4
- Sub-module wb_stream_fifo: synchronous FIFO, 33-bit entries (data + last), parameter DEPTH, with push, pop, flush, count, empty and full.

Test Plan:
1. Responder model acks 1 cycle after stb, memory[i] = i*3; base=0x100, len=4, loop=0, tready=1.
   -> adr sequence 0x100/104/108/10C; tdata 0,3,6,9; tlast only on 9; done pulses once; busy falls; exactly 4 stb rising edges.
2. Backpressure: len=8, tready=0 for 20 cycles.
   -> exactly FIFO_DEPTH=4 words fetched, then stb stays low.
   -> after tready=1, all 8 words arrive in order, none lost or duplicated.
3. Loop: base=0x0, len=3, loop=1, run 10 output words.
   -> data pattern repeats w0,w1,w2; tlast on every 3rd word; address wraps to 0x0 after 0x8; no done pulse.
4. cfg_stop asserted while WAIT_ACK, ack delayed 3 cycles.
   -> stb held until ack; acked data discarded; tvalid=0 after flush; done pulses; next start runs cleanly.
5. Responder never acks, ACK_TIMEOUT=16.
   -> stb drops 16 cycles after rising; err=1; done pulses.
   -> next cfg_start clears err.
6. Async reset asserted mid-transfer, not clock-aligned.
   -> stb, cyc and tvalid go to 0 immediately.
   -> after release, the block is IDLE; len=0 start produces a done pulse with no bus activity.
